mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage, directly downstream of EX and upstream of WB.
//  Registers ex_to_mem_bus and captures load data from the synchronous data SRAM.
//  Extracts and extends the load byte/half/word, then selects the writeback value.
//  Drives mem_to_wb_bus, plus a mem_to_id_bus forwarding path for data hazards.
// PARAMETERS
//  EX_TO_MEM_WD   80  {readen[3:0],pc[31:0],ram_en,ram_wen[3:0],sel_rf_res,rf_we,rf_waddr[4:0],ex_result[31:0]}
//  MEM_TO_WB_WD   70  {pc[31:0],rf_we,rf_waddr[4:0],rf_wdata[31:0]}
//  MEM_TO_ID_WD   38  {rf_we,rf_waddr[4:0],rf_wdata[31:0]}
//  STALL_WD       6   stall bus width; bit3 = MEM, bit4 = WB
// PORTS
//  clk             in   1             clock, all state on posedge
//  rst             in   1             synchronous, active-high reset
//  stall           in   STALL_WD      per-stage stall, 1 = Stop
//  ex_to_mem_bus   in   EX_TO_MEM_WD  EX results, layout as above
//  data_sram_rdata in   32            SRAM read data, valid 1 cycle after EX request
//  mem_to_wb_bus   out  MEM_TO_WB_WD  to WB pipeline register
//  mem_to_id_bus   out  MEM_TO_ID_WD  forwarding to ID
// BEHAVIOUR
//  Pipeline register r (EX_TO_MEM_WD), updated on posedge clk, priority order:
//   rst                        -> r = 0
//   stall[3]=Stop, stall[4]=0  -> r = 0 (bubble into MEM)
//   stall[3]=NoStop            -> r = ex_to_mem_bus
//   otherwise                  -> r holds
//  Outputs are combinational from r and the rdata hold logic. After reset every
//   output field is 0, including rf_we=0.
//  Load-data capture:
//   - Flag new_r is set to 1 on any cycle that loads r, and to 0 otherwise.
//   - On the first cycle an instruction sits in MEM (new_r=1), load data comes
//     straight from data_sram_rdata. That value is also latched into hold_r,
//     and cap_r is set to 1.
//   - On later stalled cycles (new_r=0, cap_r=1), load data comes from hold_r.
//   - cap_r and hold_r clear on rst and on any update of r.
//  readen decode, with a = ex_result[1:0], little-endian:
//   0000 none; 0001 LB; 0010 LBU; 0011 LH; 0100 LHU; 1111 LW; other codes act as none.
//   LB/LBU take byte a, sign- or zero-extended to 32 bits.
//   LH/LHU take half a[1] (a[1]=0 -> bits 15:0, a[1]=1 -> bits 31:16).
//   LW takes the full word; a is ignored, since alignment is checked upstream.
//  Writeback value: rf_wdata = sel_rf_res ? load_data : ex_result.
//   With sel_rf_res=1 and readen=none, rf_wdata = 0.
//  rf_we and rf_waddr pass through unchanged.
//   rf_waddr=0 with rf_we=1 is forwarded unchanged; ID and WB ignore register 0.
//  mem_to_id_bus carries the same rf_we/rf_waddr/rf_wdata as mem_to_wb_bus, in the same cycle.
//  Latency: 1 cycle from ex_to_mem_bus to mem_to_wb_bus; 0 cycles from data_sram_rdata to rf_wdata.
//  Stores (ram_wen != 0) issue from EX; MEM only passes their pc through, with rf_we as supplied.
//  rst mid-stall: r, hold_r, cap_r and new_r all clear on the next edge; the stalled load is dropped.
// TESTING
//  1 Reset: hold rst 2 cycles with random inputs -> mem_to_wb_bus=0 and mem_to_id_bus=0.
//  2 Pass-through ALU op: ex_result=0x12345678, rf_we=1, waddr=5, sel_rf_res=0
//    -> next cycle rf_wdata=0x12345678, waddr=5 on both buses.
//  3 Loads with rdata=0x80FF7F01: LB a=3 -> 0xFFFFFF80; LBU a=3 -> 0x00000080;
//    LH a=2 -> 0xFFFF80FF; LHU a=0 -> 0x00007F01; LW -> 0x80FF7F01.
//  4 Load held under stall: LW enters MEM with rdata=0xCAFEF00D, then stall=6'b011111
//    for 3 cycles while rdata changes to 0xDEADBEEF -> rf_wdata stays 0xCAFEF00D.
//  5 Bubble insert: stall[3]=1, stall[4]=0 for 1 cycle -> next cycle rf_we=0 and bus=0;
//    the following instruction is then accepted normally.
//  6 rst asserted during a stalled LW -> next cycle both buses are 0 and cap_r=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers EX results, captures and extends
// synchronous SRAM load data, and drives the WB bus plus the ID forwarding bus.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 80,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_ID_WD = 38,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    typedef enum logic [3:0] {
        RD_NONE = 4'b0000,
        RD_LB   = 4'b0001,
        RD_LBU  = 4'b0010,
        RD_LH   = 4'b0011,
        RD_LHU  = 4'b0100,
        RD_LW   = 4'b1111
    } readen_e;

    logic [EX_TO_MEM_WD-1:0] r;
    logic                    new_r;
    logic                    cap_r;
    logic [31:0]             hold_r;

    logic [3:0]  readen;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign {readen, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = r;

    // A bubble (MEM stopped, WB running) also counts as an update of r.
    logic bubble;
    logic advance;
    logic update_r;

    assign bubble   = stall[3] && !stall[4];
    assign advance  = !stall[3];
    assign update_r = advance || bubble;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            new_r <= 1'b0;
        end else begin
            new_r <= update_r;
            if (bubble)
                r <= '0;
            else if (advance)
                r <= ex_to_mem_bus;
        end
    end

    // The SRAM word is only valid on the first MEM cycle; keep it for stalls.
    always_ff @(posedge clk) begin
        if (rst || update_r) begin
            cap_r  <= 1'b0;
            hold_r <= '0;
        end else if (new_r) begin
            cap_r  <= 1'b1;
            hold_r <= data_sram_rdata;
        end
    end

    logic [31:0] load_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign load_word = (!new_r && cap_r) ? hold_r : data_sram_rdata;
    assign load_byte = load_word[8*ex_result[1:0] +: 8];
    assign load_half = ex_result[1] ? load_word[31:16] : load_word[15:0];

    // NOTE: default assigned first so no path through the case infers a latch.
    always_comb begin
        load_data = '0;
        case (readen)
            RD_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            RD_LBU:  load_data = {24'h0, load_byte};
            RD_LH:   load_data = {{16{load_half[15]}}, load_half};
            RD_LHU:  load_data = {16'h0, load_half};
            RD_LW:   load_data = load_word;
            default: load_data = '0;
        endcase
    end

    assign rf_wdata      = sel_rf_res ? load_data : ex_result;
    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};

    // Store controls and other stages' stall bits are not used here.
    logic unused_bits;
    assign unused_bits = ^{ram_en, ram_wen, stall[2:0], stall[STALL_WD-1:5]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for load/ALU decode plus
// hand-written sequences for reset, stall hold, bubble and reset-mid-stall.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [79:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;

    int tests  = 0;
    int failed = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  readen;
        logic [31:0] pc;
        logic [3:0]  ram_wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] ex_result;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [79:0] make_ex(logic [3:0] readen, logic [31:0] pc,
                                            logic [3:0] ram_wen, logic sel, logic we,
                                            logic [4:0] waddr, logic [31:0] ex_result);
        return {readen, pc, |ram_wen, ram_wen, sel, we, waddr, ex_result};
    endfunction

    task automatic check(string name, logic [69:0] actual, logic [69:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_buses(string name, logic [31:0] pc, logic we,
                               logic [4:0] waddr, logic [31:0] wdata);
        check({name, "_wb"}, mem_to_wb_bus, {pc, we, waddr, wdata});
        check({name, "_id"}, {32'h0, mem_to_id_bus}, {32'h0, we, waddr, wdata});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        stall           = 6'($urandom);
        ex_to_mem_bus   = {$urandom, $urandom, 16'($urandom)};
        data_sram_rdata = $urandom;

        vecs[0]  = '{4'b0000, 32'h0000_1000, 4'h0, 1'b0, 1'b1, 5'd5,  32'h1234_5678, 32'h80FF_7F01, 32'h1234_5678};
        vecs[1]  = '{4'b0001, 32'h0000_1004, 4'h0, 1'b1, 1'b1, 5'd6,  32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80};
        vecs[2]  = '{4'b0010, 32'h0000_1008, 4'h0, 1'b1, 1'b1, 5'd7,  32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080};
        vecs[3]  = '{4'b0011, 32'h0000_100C, 4'h0, 1'b1, 1'b1, 5'd8,  32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_80FF};
        vecs[4]  = '{4'b0100, 32'h0000_1010, 4'h0, 1'b1, 1'b1, 5'd9,  32'h0000_1000, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[5]  = '{4'b1111, 32'h0000_1014, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_2001, 32'h80FF_7F01, 32'h80FF_7F01};
        vecs[6]  = '{4'b0001, 32'h0000_1018, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_1001, 32'h80FF_7F01, 32'h0000_007F};
        vecs[7]  = '{4'b0001, 32'h0000_101C, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_1002, 32'h80FF_7F01, 32'hFFFF_FFFF};
        vecs[8]  = '{4'b0011, 32'h0000_1020, 4'h0, 1'b1, 1'b1, 5'd13, 32'h0000_1000, 32'h80FF_7F01, 32'h0000_7F01};
        vecs[9]  = '{4'b0100, 32'h0000_1024, 4'h0, 1'b1, 1'b1, 5'd14, 32'h0000_1002, 32'h80FF_7F01, 32'h0000_80FF};
        vecs[10] = '{4'b0000, 32'h0000_1028, 4'h0, 1'b1, 1'b1, 5'd15, 32'h5555_AAAA, 32'h80FF_7F01, 32'h0000_0000};
        vecs[11] = '{4'b0101, 32'h0000_102C, 4'h0, 1'b1, 1'b1, 5'd16, 32'h5555_AAAA, 32'h80FF_7F01, 32'h0000_0000};
        vecs[12] = '{4'b1111, 32'h0000_1030, 4'h0, 1'b0, 1'b1, 5'd17, 32'h0000_ABCC, 32'h80FF_7F01, 32'h0000_ABCC};
        vecs[13] = '{4'b0000, 32'h0000_1034, 4'h0, 1'b0, 1'b1, 5'd0,  32'hDEAD_0000, 32'h1111_2222, 32'hDEAD_0000};
        vecs[14] = '{4'b0000, 32'h0000_1038, 4'hF, 1'b0, 1'b0, 5'd3,  32'h0000_0040, 32'h1111_2222, 32'h0000_0040};

        // Reset with random inputs for two cycles.
        step();
        stall           = 6'($urandom);
        ex_to_mem_bus   = {$urandom, $urandom, 16'($urandom)};
        data_sram_rdata = $urandom;
        step();
        check_buses("reset", 32'h0, 1'b0, 5'd0, 32'h0);
        rst   = 1'b0;
        stall = 6'b0;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 15; i++) begin
            ex_to_mem_bus = make_ex(vecs[i].readen, vecs[i].pc, vecs[i].ram_wen,
                                    vecs[i].sel, vecs[i].we, vecs[i].waddr, vecs[i].ex_result);
            step();
            data_sram_rdata = vecs[i].rdata;
            #1;
            check_buses($sformatf("vec%0d", i), vecs[i].pc, vecs[i].we,
                        vecs[i].waddr, vecs[i].exp_wdata);
        end

        // Load held under stall while SRAM data changes.
        ex_to_mem_bus = make_ex(4'b1111, 32'h0000_2000, 4'h0, 1'b1, 1'b1, 5'd20, 32'h0000_0100);
        step();
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        check_buses("hold_first", 32'h0000_2000, 1'b1, 5'd20, 32'hCAFE_F00D);
        stall         = 6'b011111;
        ex_to_mem_bus = make_ex(4'b0000, 32'h0000_9999, 4'h0, 1'b0, 1'b1, 5'd1, 32'h0BAD_0BAD);
        for (int k = 0; k < 3; k++) begin
            step();
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check_buses($sformatf("hold_stall%0d", k), 32'h0000_2000, 1'b1, 5'd20, 32'hCAFE_F00D);
        end

        // Bubble insert, then the next instruction is accepted.
        stall = 6'b001000;
        step();
        check_buses("bubble", 32'h0, 1'b0, 5'd0, 32'h0);
        stall         = 6'b0;
        ex_to_mem_bus = make_ex(4'b0000, 32'h0000_3000, 4'h0, 1'b0, 1'b1, 5'd21, 32'h0000_7777);
        step();
        check_buses("after_bubble", 32'h0000_3000, 1'b1, 5'd21, 32'h0000_7777);

        // Reset asserted during a stalled load.
        ex_to_mem_bus = make_ex(4'b1111, 32'h0000_4000, 4'h0, 1'b1, 1'b1, 5'd22, 32'h0000_0200);
        step();
        data_sram_rdata = 32'h1357_9BDF;
        stall           = 6'b011111;
        step();
        data_sram_rdata = 32'h2468_ACE0;
        #1;
        check_buses("pre_rst_stall", 32'h0000_4000, 1'b1, 5'd22, 32'h1357_9BDF);
        rst = 1'b1;
        step();
        check_buses("rst_mid_stall", 32'h0, 1'b0, 5'd0, 32'h0);
        check("rst_cap_r", {69'h0, dut.cap_r}, 70'h0);
        rst = 1'b0;
        step();
        check_buses("post_rst_stall", 32'h0, 1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
